// File: rtl/punc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : punc_control_fsm
//  Brief    : Multi-cycle LC3 control sequencer driving the PUnC datapath
//             through FETCH / DECODE / EXECUTE (/ EXECUTE2) until HALT.
//  Revision : 1.0
// ============================================================================
module punc_control_fsm #(
  parameter logic [7:0] HALT_TRAPVECT = 8'h25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  output logic        halted,
  output logic        mem_wr_en,
  output logic [2:0]  mem_r_addr_sel,
  output logic        state2_STI,
  output logic        STR,
  output logic [2:0]  RF_wr_addr,
  output logic        RF_wr_en,
  output logic [2:0]  RF_r_addr_0,
  output logic [2:0]  RF_r_addr_1,
  output logic [1:0]  RF_w_data_sel,
  output logic        ir_ld,
  output logic        JMP_RET_JSRR,
  output logic        pc_ld,
  output logic        pc_clr,
  output logic        pc_up,
  output logic        add_const,
  output logic [1:0]  alu_sel,
  output logic        cc_en,
  output logic        n,
  output logic        z,
  output logic        p,
  output logic [10:0] const_n,
  output logic [3:0]  SEXT_Select
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXECUTE  = 3'd2,
    S_EXECUTE2 = 3'd3,
    S_HALT     = 3'd4
  } state_t;

  localparam logic [3:0] c_OP_BR   = 4'b0000;
  localparam logic [3:0] c_OP_ADD  = 4'b0001;
  localparam logic [3:0] c_OP_LD   = 4'b0010;
  localparam logic [3:0] c_OP_ST   = 4'b0011;
  localparam logic [3:0] c_OP_JSR  = 4'b0100;
  localparam logic [3:0] c_OP_AND  = 4'b0101;
  localparam logic [3:0] c_OP_LDR  = 4'b0110;
  localparam logic [3:0] c_OP_STR  = 4'b0111;
  localparam logic [3:0] c_OP_NOT  = 4'b1001;
  localparam logic [3:0] c_OP_LDI  = 4'b1010;
  localparam logic [3:0] c_OP_STI  = 4'b1011;
  localparam logic [3:0] c_OP_JMP  = 4'b1100;
  localparam logic [3:0] c_OP_LEA  = 4'b1110;
  localparam logic [3:0] c_OP_TRAP = 4'b1111;

  localparam logic [3:0] c_SEXT_IMM5  = 4'b1000;
  localparam logic [3:0] c_SEXT_OFF6  = 4'b0100;
  localparam logic [3:0] c_SEXT_OFF9  = 4'b0010;
  localparam logic [3:0] c_SEXT_OFF11 = 4'b0001;

  localparam logic [1:0] c_ALU_PASS = 2'd0;
  localparam logic [1:0] c_ALU_ADD  = 2'd1;
  localparam logic [1:0] c_ALU_AND  = 2'd2;
  localparam logic [1:0] c_ALU_NOT  = 2'd3;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_op;
  logic [2:0] w_dr;
  logic [2:0] w_sr1;
  logic [2:0] w_sr2;
  logic       w_trap_halt;

  assign w_op    = ir[15:12];
  assign w_dr    = ir[11:9];
  assign w_sr1   = ir[8:6];
  assign w_sr2   = ir[2:0];
  assign const_n = ir[10:0];

  // Every TRAP halts; the documented HALT vector is matched only for visibility.
  assign w_trap_halt = (ir[7:0] == HALT_TRAPVECT) | 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    halted         = 1'b0;
    mem_wr_en      = 1'b0;
    mem_r_addr_sel = 3'd0;
    state2_STI     = 1'b0;
    STR            = 1'b0;
    RF_wr_addr     = 3'd0;
    RF_wr_en       = 1'b0;
    RF_r_addr_0    = 3'd0;
    RF_r_addr_1    = 3'd0;
    RF_w_data_sel  = 2'd0;
    ir_ld          = 1'b0;
    JMP_RET_JSRR   = 1'b0;
    pc_ld          = 1'b0;
    pc_clr         = 1'b0;
    pc_up          = 1'b0;
    add_const      = 1'b0;
    alu_sel        = c_ALU_PASS;
    cc_en          = 1'b0;
    n              = 1'b0;
    z              = 1'b0;
    p              = 1'b0;
    SEXT_Select    = 4'b0000;

    if (rst) begin
      // Reset masks every strobe so an aborted instruction writes nothing.
      pc_clr = 1'b1;
    end else begin
      case (r_state)
        S_FETCH: begin
          mem_r_addr_sel = 3'd0;
          ir_ld          = 1'b1;
          w_next         = S_DECODE;
        end
        S_DECODE: begin
          pc_up  = 1'b1;
          w_next = S_EXECUTE;
        end
        S_EXECUTE: begin
          w_next = S_FETCH;
          case (w_op)
            c_OP_ADD, c_OP_AND: begin
              alu_sel       = (w_op == c_OP_ADD) ? c_ALU_ADD : c_ALU_AND;
              add_const     = ir[5];
              SEXT_Select   = c_SEXT_IMM5;
              RF_r_addr_0   = w_sr1;
              RF_r_addr_1   = w_sr2;
              RF_wr_addr    = w_dr;
              RF_wr_en      = 1'b1;
              RF_w_data_sel = 2'd0;
              cc_en         = 1'b1;
            end
            c_OP_NOT: begin
              alu_sel     = c_ALU_NOT;
              RF_r_addr_0 = w_sr1;
              RF_wr_addr  = w_dr;
              RF_wr_en    = 1'b1;
              cc_en       = 1'b1;
            end
            c_OP_BR: begin
              {n, z, p}   = w_dr;
              SEXT_Select = c_SEXT_OFF9;
            end
            c_OP_JMP: begin
              alu_sel      = c_ALU_PASS;
              RF_r_addr_0  = w_sr1;
              JMP_RET_JSRR = 1'b1;
              pc_ld        = 1'b1;
            end
            c_OP_JSR: begin
              RF_wr_addr    = 3'd7;
              RF_wr_en      = 1'b1;
              RF_w_data_sel = 2'd1;
              pc_ld         = 1'b1;
              if (ir[11]) begin
                SEXT_Select  = c_SEXT_OFF11;
              end else begin
                alu_sel      = c_ALU_PASS;
                RF_r_addr_0  = w_sr1;
                JMP_RET_JSRR = 1'b1;
              end
            end
            c_OP_LD: begin
              SEXT_Select    = c_SEXT_OFF9;
              mem_r_addr_sel = 3'd1;
              RF_wr_addr     = w_dr;
              RF_wr_en       = 1'b1;
              RF_w_data_sel  = 2'd2;
            end
            c_OP_LEA: begin
              SEXT_Select   = c_SEXT_OFF9;
              RF_wr_addr    = w_dr;
              RF_wr_en      = 1'b1;
              RF_w_data_sel = 2'd3;
            end
            c_OP_LDR: begin
              alu_sel        = c_ALU_ADD;
              add_const      = 1'b1;
              SEXT_Select    = c_SEXT_OFF6;
              RF_r_addr_0    = w_sr1;
              mem_r_addr_sel = 3'd4;
              RF_wr_addr     = w_dr;
              RF_wr_en       = 1'b1;
              RF_w_data_sel  = 2'd2;
            end
            c_OP_ST: begin
              SEXT_Select = c_SEXT_OFF9;
              alu_sel     = c_ALU_PASS;
              RF_r_addr_0 = w_dr;
              mem_wr_en   = 1'b1;
            end
            c_OP_STR: begin
              STR         = 1'b1;
              alu_sel     = c_ALU_ADD;
              add_const   = 1'b1;
              SEXT_Select = c_SEXT_OFF6;
              RF_r_addr_0 = w_sr1;
              RF_r_addr_1 = w_dr;
              mem_wr_en   = 1'b1;
            end
            c_OP_LDI, c_OP_STI: begin
              // First access only captures the pointer into the indirect latch.
              SEXT_Select    = c_SEXT_OFF9;
              mem_r_addr_sel = 3'd1;
              w_next         = S_EXECUTE2;
            end
            c_OP_TRAP: begin
              w_next = w_trap_halt ? S_HALT : S_FETCH;
            end
            default: begin
              w_next = S_FETCH;
            end
          endcase
        end
        S_EXECUTE2: begin
          w_next = S_FETCH;
          if (w_op == c_OP_LDI) begin
            mem_r_addr_sel = 3'd2;
            RF_wr_addr     = w_dr;
            RF_wr_en       = 1'b1;
            RF_w_data_sel  = 2'd2;
          end else begin
            state2_STI  = 1'b1;
            alu_sel     = c_ALU_PASS;
            RF_r_addr_0 = w_dr;
            mem_wr_en   = 1'b1;
          end
        end
        S_HALT: begin
          halted = 1'b1;
          w_next = S_HALT;
        end
        default: begin
          w_next = S_FETCH;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_punc_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_punc_control_fsm
//  Brief    : Scoreboard bench for punc_control_fsm with randomized LC3 words.
//  Revision : 1.0
// ============================================================================
module tb_punc_control_fsm;

  typedef struct packed {
    logic        halted;
    logic        mem_wr_en;
    logic [2:0]  mem_r_addr_sel;
    logic        state2_STI;
    logic        STR;
    logic [2:0]  RF_wr_addr;
    logic        RF_wr_en;
    logic [2:0]  RF_r_addr_0;
    logic [2:0]  RF_r_addr_1;
    logic [1:0]  RF_w_data_sel;
    logic        ir_ld;
    logic        JMP_RET_JSRR;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_up;
    logic        add_const;
    logic [1:0]  alu_sel;
    logic        cc_en;
    logic        n;
    logic        z;
    logic        p;
    logic [10:0] const_n;
    logic [3:0]  SEXT_Select;
  } out_t;

  typedef struct {
    out_t        exp;
    string       name;
    logic [15:0] iword;
  } sb_item_t;

  logic        clk;
  logic        rst;
  logic [15:0] ir;
  out_t        act;

  logic        halted, mem_wr_en, state2_STI, STR, RF_wr_en, ir_ld, JMP_RET_JSRR;
  logic        pc_ld, pc_clr, pc_up, add_const, cc_en, n, z, p;
  logic [2:0]  mem_r_addr_sel, RF_wr_addr, RF_r_addr_0, RF_r_addr_1;
  logic [1:0]  RF_w_data_sel, alu_sel;
  logic [10:0] const_n;
  logic [3:0]  SEXT_Select;

  sb_item_t sb[$];
  int       n_vec;
  int       n_bad;

  punc_control_fsm #(.HALT_TRAPVECT(8'h25)) dut (
    .clk(clk), .rst(rst), .ir(ir), .halted(halted), .mem_wr_en(mem_wr_en),
    .mem_r_addr_sel(mem_r_addr_sel), .state2_STI(state2_STI), .STR(STR),
    .RF_wr_addr(RF_wr_addr), .RF_wr_en(RF_wr_en), .RF_r_addr_0(RF_r_addr_0),
    .RF_r_addr_1(RF_r_addr_1), .RF_w_data_sel(RF_w_data_sel), .ir_ld(ir_ld),
    .JMP_RET_JSRR(JMP_RET_JSRR), .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_up(pc_up),
    .add_const(add_const), .alu_sel(alu_sel), .cc_en(cc_en), .n(n), .z(z), .p(p),
    .const_n(const_n), .SEXT_Select(SEXT_Select)
  );

  assign act = {halted, mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr,
                RF_wr_en, RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld,
                JMP_RET_JSRR, pc_ld, pc_clr, pc_up, add_const, alu_sel, cc_en,
                n, z, p, const_n, SEXT_Select};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what each instruction asks of the datapath in a given cycle.
  function automatic int instr_len(input logic [15:0] i);
    return (i[15:12] == 4'hA || i[15:12] == 4'hB) ? 4 : 3;
  endfunction

  function automatic out_t ref_reset(input logic [15:0] i);
    out_t e = '0;
    e.pc_clr  = 1'b1;
    e.const_n = i[10:0];
    return e;
  endfunction

  function automatic out_t ref_halt(input logic [15:0] i);
    out_t e = '0;
    e.halted  = 1'b1;
    e.const_n = i[10:0];
    return e;
  endfunction

  function automatic out_t ref_cycle(input logic [15:0] i, input int ph);
    out_t       e   = '0;
    logic [2:0] dr  = i[11:9];
    logic [2:0] sr1 = i[8:6];
    e.const_n = i[10:0];
    if (ph == 0) begin
      e.ir_ld = 1'b1;
    end else if (ph == 1) begin
      e.pc_up = 1'b1;
    end else if (ph == 2) begin
      case (i[15:12])
        4'h1, 4'h5: begin
          e.alu_sel = (i[15:12] == 4'h1) ? 2'd1 : 2'd2;
          e.add_const = i[5]; e.SEXT_Select = 4'b1000;
          e.RF_r_addr_0 = sr1; e.RF_r_addr_1 = i[2:0];
          e.RF_wr_addr = dr; e.RF_wr_en = 1'b1; e.cc_en = 1'b1;
        end
        4'h9: begin
          e.alu_sel = 2'd3; e.RF_r_addr_0 = sr1;
          e.RF_wr_addr = dr; e.RF_wr_en = 1'b1; e.cc_en = 1'b1;
        end
        4'h0: begin
          {e.n, e.z, e.p} = dr; e.SEXT_Select = 4'b0010;
        end
        4'hC: begin
          e.RF_r_addr_0 = sr1; e.JMP_RET_JSRR = 1'b1; e.pc_ld = 1'b1;
        end
        4'h4: begin
          e.RF_wr_addr = 3'd7; e.RF_wr_en = 1'b1; e.RF_w_data_sel = 2'd1; e.pc_ld = 1'b1;
          if (i[11]) e.SEXT_Select = 4'b0001;
          else begin e.RF_r_addr_0 = sr1; e.JMP_RET_JSRR = 1'b1; end
        end
        4'h2: begin
          e.SEXT_Select = 4'b0010; e.mem_r_addr_sel = 3'd1;
          e.RF_wr_addr = dr; e.RF_wr_en = 1'b1; e.RF_w_data_sel = 2'd2;
        end
        4'hE: begin
          e.SEXT_Select = 4'b0010;
          e.RF_wr_addr = dr; e.RF_wr_en = 1'b1; e.RF_w_data_sel = 2'd3;
        end
        4'h6: begin
          e.alu_sel = 2'd1; e.add_const = 1'b1; e.SEXT_Select = 4'b0100;
          e.RF_r_addr_0 = sr1; e.mem_r_addr_sel = 3'd4;
          e.RF_wr_addr = dr; e.RF_wr_en = 1'b1; e.RF_w_data_sel = 2'd2;
        end
        4'h3: begin
          e.SEXT_Select = 4'b0010; e.RF_r_addr_0 = dr; e.mem_wr_en = 1'b1;
        end
        4'h7: begin
          e.STR = 1'b1; e.alu_sel = 2'd1; e.add_const = 1'b1; e.SEXT_Select = 4'b0100;
          e.RF_r_addr_0 = sr1; e.RF_r_addr_1 = dr; e.mem_wr_en = 1'b1;
        end
        4'hA, 4'hB: begin
          e.SEXT_Select = 4'b0010; e.mem_r_addr_sel = 3'd1;
        end
        default: ;
      endcase
    end else begin
      if (i[15:12] == 4'hA) begin
        e.mem_r_addr_sel = 3'd2;
        e.RF_wr_addr = dr; e.RF_wr_en = 1'b1; e.RF_w_data_sel = 2'd2;
      end else begin
        e.state2_STI = 1'b1; e.RF_r_addr_0 = dr; e.mem_wr_en = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic [15:0] i, input out_t e, input string nm);
    sb_item_t it;
    @(posedge clk);
    #1;
    rst = r;
    ir  = i;
    it.exp = e; it.name = nm; it.iword = i;
    sb.push_back(it);
  endtask

  // Runs one instruction; abort_at >= 0 asserts rst in that cycle instead.
  task automatic run_instr(input logic [15:0] i, input int abort_at);
    for (int ph = 0; ph < instr_len(i); ph++) begin
      if (ph == abort_at) begin
        drive(1'b1, i, ref_reset(i), "abort_rst");
        return;
      end
      drive(1'b0, i, ref_cycle(i, ph), $sformatf("op%h_ph%0d", i[15:12], ph));
    end
  endtask

  // Monitor: every cycle is an output presentation; compare mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_item_t it;
      it = sb.pop_front();
      n_vec++;
      if (act !== it.exp) begin
        n_bad++;
        $display("FAIL %s ir=%h got=%h want=%h", it.name, it.iword, act, it.exp);
      end
    end
  end

  initial begin
    logic [15:0] w;
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    ir    = 16'h0000;

    drive(1'b1, 16'h1261, ref_reset(16'h1261), "reset0");
    drive(1'b1, 16'h1261, ref_reset(16'h1261), "reset1");

    run_instr(16'h1261, -1);
    run_instr(16'h0A02, -1);
    run_instr(16'hA203, -1);
    run_instr(16'h4802, -1);
    run_instr(16'hB5C0, -1);
    run_instr(16'h4180, -1);
    run_instr(16'h3A05, 2);
    run_instr(16'h1261, -1);

    for (int k = 0; k < 200; k++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF) w[15:12] = 4'h7;
      if ($urandom_range(0, 15) == 0) run_instr(w, $urandom_range(0, instr_len(w) - 1));
      else                            run_instr(w, -1);
    end

    run_instr(16'hF025, -1);
    for (int k = 0; k < 20; k++) begin
      w = 16'($urandom);
      drive(1'b0, w, ref_halt(w), "halt_hold");
    end
    drive(1'b1, 16'h1261, ref_reset(16'h1261), "halt_reset");
    run_instr(16'h5AA3, -1);
    run_instr(16'hF0FF, -1);
    drive(1'b0, 16'h0000, ref_halt(16'h0000), "halt_any_trap");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
